// File: rtl/vud_pkg.sv
// Shared constants and FSM encoding for the counter ctrl-nibble generator.
package vud_pkg;

  localparam int CTRL_CLR_N  = 3;
  localparam int CTRL_STEP   = 2;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_COARSE = 0;

  // Button slot order in the conditioned-input vectors
  localparam int NBTN    = 4;
  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int BTN_CO  = 2;
  localparam int BTN_CLR = 3;

  localparam int ACCEL_THR = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FIRST,
    ST_DELAY,
    ST_REPEAT
  } vud_state_e;

endpackage

// File: rtl/vud_debounce.sv
// One button lane: 2-flop synchroniser, stability counter, debounced level and
// one-cycle rise pulse aligned with the level's rising edge.
module vud_debounce #(
  parameter int DEB_CYCLES = 1000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Any cycle where the synchronised value agrees with the level restarts the count
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/vud_ctrl_gen.sv
// Push-button front end driving the up/down counter ctrl nibble {clr_n, step, dir, coarse}.
// Optional VUD_CTRL_ACCEL_EN: from the 9th auto-repeat step of a hold, force coarse steps.
module vud_ctrl_gen
  import vud_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_RATE  = 10000,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_coarse,
  input  logic       btn_clr,
  output logic [3:0] ctrl,
  output logic       repeating
);

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);

  logic [NBTN-1:0] raw, lvl, press;
  assign raw = {btn_clr, btn_coarse, btn_dn, btn_up};

  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    vud_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw[g]),
      .level_o(lvl[g]),
      .rise_o (press[g])
    );
  end

  // Coarse is a level select; its press edge has no consumer
  logic unused_co_press;
  assign unused_co_press = press[BTN_CO];

  vud_state_e       state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             step_d, clr_d, rep_step, held_ok, accel_force;

  // Outputs are registered from the transition, so a step lands the cycle the FSM enters FIRST/REPEAT
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    tmr_d    = tmr_q;
    step_d   = 1'b0;
    clr_d    = 1'b0;
    rep_step = 1'b0;
    held_ok  = dir_q ? (lvl[BTN_UP] & ~lvl[BTN_DN]) : (lvl[BTN_DN] & ~lvl[BTN_UP]);
    unique case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (press[BTN_CLR]) begin
          state_d = ST_CLEAR;
          clr_d   = 1'b1;
        end else if (press[BTN_UP] && !lvl[BTN_DN]) begin
          state_d = ST_FIRST;
          dir_d   = 1'b1;
          step_d  = 1'b1;
          tmr_d   = DELAY_LD;
        end else if (press[BTN_DN] && !lvl[BTN_UP]) begin
          state_d = ST_FIRST;
          dir_d   = 1'b0;
          step_d  = 1'b1;
          tmr_d   = DELAY_LD;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
      default: begin
        tmr_d = (tmr_q != '0) ? tmr_q - TMR_ONE : '0;
        if (press[BTN_CLR]) begin
          state_d = ST_CLEAR;
          clr_d   = 1'b1;
          tmr_d   = '0;
        end else if (!held_ok) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_ONE) begin
          state_d  = ST_REPEAT;
          step_d   = 1'b1;
          rep_step = 1'b1;
          tmr_d    = RATE_LD;
        end else if (state_q == ST_FIRST) begin
          state_d = ST_DELAY;
        end
      end
    endcase
  end

`ifdef VUD_CTRL_ACCEL_EN
  logic [3:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_IDLE || state_q == ST_CLEAR) begin
      acc_d = '0;
    end else if (rep_step && acc_q < 4'(ACCEL_THR)) begin
      acc_d = acc_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign accel_force = rep_step & (acc_q >= 4'(ACCEL_THR));
`else
  assign accel_force = 1'b0;
`endif

  always_comb begin
    ctrl_d              = '0;
    ctrl_d[CTRL_CLR_N]  = ~clr_d;
    ctrl_d[CTRL_STEP]   = step_d | clr_d;
    ctrl_d[CTRL_DIR]    = dir_d;
    ctrl_d[CTRL_COARSE] = lvl[BTN_CO] | accel_force;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      tmr_q   <= '0;
      ctrl_q  <= 4'b1000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign repeating = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_vud_ctrl_gen.sv
// Scoreboard bench: stimulus pushes expected step/clear cycles, a negedge monitor checks them.
module tb_vud_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_dn, btn_coarse, btn_clr;
  logic [3:0] ctrl;
  logic       repeating;

  vud_ctrl_gen #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5),
    .CNT_W       (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .btn_coarse(btn_coarse),
    .btn_clr   (btn_clr),
    .ctrl      (ctrl),
    .repeating (repeating)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ctrl;
    logic       rep;
    int         gap;   // cycles since previous strobe, -1 = don't care
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0, bad = 0;
  int   cyc = 0, last_cyc = 0, steps_seen = 0, steps_exp = 0;

`ifdef VUD_CTRL_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  always @(posedge clk) cyc++;

  // Monitor: every strobe cycle (step or clear) must match the head of the queue
  always @(negedge clk) begin
    if (rst === 1'b1 && ctrl[2] === 1'b1) begin
      steps_seen++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got ctrl=%b rep=%b, want no strobe", ctrl, repeating);
      end else begin
        e = sbq.pop_front();
        if (ctrl !== e.ctrl || repeating !== e.rep || (e.gap >= 0 && cyc - last_cyc != e.gap)) begin
          bad++;
          $display("FAIL strobe: got ctrl=%b rep=%b gap=%0d, want ctrl=%b rep=%b gap=%0d",
                   ctrl, repeating, cyc - last_cyc, e.ctrl, e.rep, e.gap);
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input logic r, input int g);
    exp_t x;
    x.ctrl = c; x.rep = r; x.gap = g;
    sbq.push_back(x);
    steps_exp++;
  endtask

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got {ctrl,rep}=%b want %b", nm, act, want);
    end
  endtask

  task automatic drained(input string nm);
    total++;
    if (sbq.size() != 0 || steps_seen != steps_exp) begin
      bad++;
      $display("FAIL %s: got strobes=%0d pending=%0d, want strobes=%0d pending=0",
               nm, steps_seen, sbq.size(), steps_exp);
    end
  endtask

  initial begin
    rst = 1'b0; btn_up = 0; btn_dn = 0; btn_coarse = 0; btn_clr = 0;
    #23 rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      chk("reset_idle", {ctrl, repeating}, 5'b1000_0);
    end

    // 2-cycle bounce is rejected, then a 10-cycle hold gives exactly one up step
    btn_up = 1; cycles(2); btn_up = 0; cycles(10);
    push(4'b1110, 1'b0, -1);
    btn_up = 1; cycles(10); btn_up = 0; cycles(20);
    chk("up_single_after", {ctrl, repeating}, 5'b1010_0);
    drained("up_single");

    // dn held 60 cycles with coarse: step at +7, +27, then every 5 up to +62; release wins at +67
    btn_coarse = 1; cycles(10);
    push(4'b1101, 1'b0, -1);
    push(4'b1101, 1'b1, 20);
    for (int k = 0; k < 7; k++) push(4'b1101, 1'b1, 5);
    btn_dn = 1; cycles(60); btn_dn = 0; cycles(20);
    chk("dn_repeat_after", {ctrl, repeating}, 5'b1001_0);
    drained("dn_repeat");

    // Both pressed together, then dn released while up still held: no strobes
    btn_coarse = 0; cycles(10);
    btn_up = 1; btn_dn = 1; cycles(15);
    btn_dn = 0; cycles(20);
    btn_up = 0; cycles(15);
    drained("both_pressed");

    // Clear during REPEAT preempts the due step; no steps while up stays held afterwards
    push(4'b1110, 1'b0, -1);
    push(4'b1110, 1'b1, 20);
    push(4'b1110, 1'b1, 5);
    push(4'b0110, 1'b0, 5);
    btn_up = 1; cycles(30);
    btn_clr = 1; cycles(8); btn_clr = 0; cycles(30);
    btn_up = 0; cycles(20);
    chk("clear_after", {ctrl, repeating}, 5'b1010_0);
    drained("clear_in_repeat");

    // Reset mid-repeat returns to the reset state immediately
    push(4'b1110, 1'b0, -1);
    push(4'b1110, 1'b1, 20);
    btn_up = 1; cycles(30);
    rst = 1'b0; #1;
    chk("reset_midop", {ctrl, repeating}, 5'b1000_0);
    btn_up = 0; cycles(3);
    rst = 1'b1; cycles(20);
    chk("reset_recover", {ctrl, repeating}, 5'b1000_0);
    drained("reset_midop");

    // Long up hold, coarse low: 16 repeat steps; accel build forces coarse from the 9th
    push(4'b1110, 1'b0, -1);
    for (int k = 1; k <= 16; k++)
      push((ACCEL && k >= 9) ? 4'b1111 : 4'b1110, 1'b1, (k == 1) ? 20 : 5);
    btn_up = 1; cycles(100); btn_up = 0; cycles(20);
    chk("accel_after", {ctrl, repeating}, 5'b1010_0);
    drained("long_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
